// File: rtl/mcycle_pkg.sv
// Shared encodings for the multicycle MIPS main control FSM.
// MCYCLE_ADDI_EN adds the addi execute/writeback states.
package mcycle_pkg;

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        RTYPEEX = 4'd6,
        RTYPEWB = 4'd7,
        BEQEX   = 4'd8,
        JEX     = 4'd9
`ifdef MCYCLE_ADDI_EN
        ,
        ADDIEX  = 4'd10,
        ADDIWB  = 4'd11
`endif
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] ALUB_REGB  = 2'b00;
    localparam logic [1:0] ALUB_FOUR  = 2'b01;
    localparam logic [1:0] ALUB_IMM   = 2'b10;
    localparam logic [1:0] ALUB_IMMSH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       mem_req;
        logic       iord;
        logic       memwrite;
        logic       irwrite;
        logic       regdst;
        logic       memtoreg;
        logic       regwrite;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] pcsrc;
        logic [1:0] aluop;
        logic       pcwrite;
        logic       branch;
    } ctrl_t;

    // Opcodes that DECODE dispatches; everything else is a NOP flagged illegal.
    function automatic logic op_known(input logic [5:0] op);
        logic known;
        case (op)
            OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J: known = 1'b1;
`ifdef MCYCLE_ADDI_EN
            OP_ADDI: known = 1'b1;
`endif
            default: known = 1'b0;
        endcase
        return known;
    endfunction

endpackage

// File: rtl/mcycle_outdec.sv
// Moore decode of the control state into datapath strobes and mux selects.
// MCYCLE_ADDI_EN adds the addi state decodes.
module mcycle_outdec
    import mcycle_pkg::*;
(
    input  state_t state,
    input  logic   mem_ready,
    output ctrl_t  ctrl
);

    always_comb begin
        ctrl = '0;
        case (state)
            FETCH: begin
                ctrl.mem_req = 1'b1;
                ctrl.alusrcb = ALUB_FOUR;
                ctrl.irwrite = mem_ready;
                ctrl.pcwrite = mem_ready;
            end
            DECODE: ctrl.alusrcb = ALUB_IMMSH;
            MEMADR: begin
                ctrl.alusrca = 1'b1;
                ctrl.alusrcb = ALUB_IMM;
            end
            MEMRD: begin
                ctrl.mem_req = 1'b1;
                ctrl.iord    = 1'b1;
            end
            MEMWB: begin
                ctrl.regwrite = 1'b1;
                ctrl.memtoreg = 1'b1;
            end
            // Write strobe stays up through stalls; memory commits on mem_ready.
            MEMWR: begin
                ctrl.mem_req  = 1'b1;
                ctrl.iord     = 1'b1;
                ctrl.memwrite = 1'b1;
            end
            RTYPEEX: begin
                ctrl.alusrca = 1'b1;
                ctrl.aluop   = ALUOP_FUNCT;
            end
            RTYPEWB: begin
                ctrl.regwrite = 1'b1;
                ctrl.regdst   = 1'b1;
            end
            BEQEX: begin
                ctrl.alusrca = 1'b1;
                ctrl.aluop   = ALUOP_SUB;
                ctrl.pcsrc   = PCSRC_ALUOUT;
                ctrl.branch  = 1'b1;
            end
`ifdef MCYCLE_ADDI_EN
            ADDIEX: begin
                ctrl.alusrca = 1'b1;
                ctrl.alusrcb = ALUB_IMM;
            end
            ADDIWB: ctrl.regwrite = 1'b1;
`endif
            JEX: begin
                ctrl.pcsrc   = PCSRC_JUMP;
                ctrl.pcwrite = 1'b1;
            end
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/mcycle_control.sv
// Multicycle MIPS main control: state register, next-state logic and strobe gating.
// MCYCLE_ADDI_EN enables the addi path; otherwise addi is treated as illegal.
module mcycle_control
    import mcycle_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       iord,
    output logic       memwrite,
    output logic       irwrite,
    output logic       regdst,
    output logic       memtoreg,
    output logic       regwrite,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic [1:0] aluop,
    output logic       pcen,
    output logic       illegal_op,
    output logic [3:0] state
);

    state_t state_q;
    state_t state_d;
    ctrl_t  ctrl;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= FETCH;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            FETCH:  if (mem_ready) state_d = DECODE;
            DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_RTYPE:     state_d = RTYPEEX;
                    OP_BEQ:       state_d = BEQEX;
`ifdef MCYCLE_ADDI_EN
                    OP_ADDI:      state_d = ADDIEX;
`endif
                    OP_J:         state_d = JEX;
                    default:      state_d = FETCH;
                endcase
            end
            MEMADR: begin
                if (opcode == OP_LW)      state_d = MEMRD;
                else if (opcode == OP_SW) state_d = MEMWR;
                else                      state_d = FETCH;
            end
            MEMRD:   if (mem_ready) state_d = MEMWB;
            MEMWR:   if (mem_ready) state_d = FETCH;
            RTYPEEX: state_d = RTYPEWB;
`ifdef MCYCLE_ADDI_EN
            ADDIEX:  state_d = ADDIWB;
`endif
            default: state_d = FETCH;
        endcase
    end

    mcycle_outdec u_outdec (
        .state     (state_q),
        .mem_ready (mem_ready),
        .ctrl      (ctrl)
    );

    // The state register clears asynchronously to FETCH, whose decode raises
    // mem_req/irwrite; gate the strobes so nothing fires while rst_n is low.
    assign mem_req    = ctrl.mem_req  & rst_n;
    assign irwrite    = ctrl.irwrite  & rst_n;
    assign memwrite   = ctrl.memwrite & rst_n;
    assign regwrite   = ctrl.regwrite & rst_n;
    assign pcen       = rst_n & (ctrl.pcwrite | (ctrl.branch & zero));
    assign illegal_op = rst_n & (state_q == DECODE) & ~op_known(opcode);

    assign iord     = ctrl.iord;
    assign regdst   = ctrl.regdst;
    assign memtoreg = ctrl.memtoreg;
    assign alusrca  = ctrl.alusrca;
    assign alusrcb  = ctrl.alusrcb;
    assign pcsrc    = ctrl.pcsrc;
    assign aluop    = ctrl.aluop;
    assign state    = state_q;

endmodule

// File: tb/tb_mcycle_control.sv
// Self-checking bench for mcycle_control: directed scenarios plus a randomized
// instruction stream checked against a phase-level model of each instruction.
module tb_mcycle_control;
    import mcycle_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] opcode = 6'd0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic       mem_req, iord, memwrite, irwrite, regdst, memtoreg, regwrite;
    logic       alusrca, pcen, illegal_op;
    logic [1:0] alusrcb, pcsrc, aluop;
    logic [3:0] state;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mcycle_control dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .mem_req(mem_req), .iord(iord), .memwrite(memwrite), .irwrite(irwrite),
        .regdst(regdst), .memtoreg(memtoreg), .regwrite(regwrite), .alusrca(alusrca),
        .alusrcb(alusrcb), .pcsrc(pcsrc), .aluop(aluop), .pcen(pcen),
        .illegal_op(illegal_op), .state(state)
    );

    task automatic test_reset;
        rst_n = 1'b0; mem_ready = 1'b1; opcode = OP_LW;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_vec++; if (state !== 4'd0) begin n_bad++; $display("FAIL reset_state got %0d want 0", state); end
        n_vec++; if (alusrcb !== 2'b01) begin n_bad++; $display("FAIL reset_alusrcb got %b want 01", alusrcb); end
        n_vec++; if ({mem_req, irwrite, pcen, memwrite, regwrite, illegal_op} !== 6'b0) begin
            n_bad++; $display("FAIL reset_strobes got %b want 000000", {mem_req, irwrite, pcen, memwrite, regwrite, illegal_op});
        end
        n_vec++; if ({iord, regdst, memtoreg, alusrca, pcsrc, aluop} !== 8'b0) begin
            n_bad++; $display("FAIL reset_others got %b want 00000000", {iord, regdst, memtoreg, alusrca, pcsrc, aluop});
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_rtype;
        logic [3:0] es [4];
        es = '{FETCH, DECODE, RTYPEEX, RTYPEWB};
        opcode = OP_RTYPE; mem_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_vec++; if (state !== es[i]) begin n_bad++; $display("FAIL rtype_state[%0d] got %0d want %0d", i, state, es[i]); end
            if (i == 0) begin
                n_vec++; if ({irwrite, pcen, mem_req} !== 3'b111) begin n_bad++; $display("FAIL rtype_fetch got %b want 111", {irwrite, pcen, mem_req}); end
            end
            if (i == 1) begin
                n_vec++; if (alusrcb !== 2'b11) begin n_bad++; $display("FAIL rtype_decode_alusrcb got %b want 11", alusrcb); end
            end
            if (i == 2) begin
                n_vec++; if ({aluop, alusrca} !== 3'b101) begin n_bad++; $display("FAIL rtype_ex got %b want 101", {aluop, alusrca}); end
            end
            if (i == 3) begin
                n_vec++; if ({regwrite, regdst} !== 2'b11) begin n_bad++; $display("FAIL rtype_wb got %b want 11", {regwrite, regdst}); end
            end
            @(posedge clk); #1;
        end
        n_vec++; if (state !== 4'd0) begin n_bad++; $display("FAIL rtype_end got %0d want 0", state); end
    endtask

    task automatic test_lw_stall;
        logic [3:0] es [7];
        logic       mr [7];
        es = '{FETCH, DECODE, MEMADR, MEMRD, MEMRD, MEMRD, MEMWB};
        mr = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        opcode = OP_LW;
        for (int i = 0; i < 7; i++) begin
            mem_ready = mr[i];
            @(negedge clk);
            n_vec++; if (state !== es[i]) begin n_bad++; $display("FAIL lw_state[%0d] got %0d want %0d", i, state, es[i]); end
            if (i >= 3 && i <= 5) begin
                n_vec++; if ({iord, mem_req, regwrite} !== 3'b110) begin n_bad++; $display("FAIL lw_memrd[%0d] got %b want 110", i, {iord, mem_req, regwrite}); end
            end
            if (i == 6) begin
                n_vec++; if ({regwrite, memtoreg, iord} !== 3'b110) begin n_bad++; $display("FAIL lw_wb got %b want 110", {regwrite, memtoreg, iord}); end
            end
            @(posedge clk); #1;
        end
        n_vec++; if (state !== 4'd0) begin n_bad++; $display("FAIL lw_end got %0d want 0", state); end
    endtask

    task automatic test_beq(input logic z);
        opcode = OP_BEQ; mem_ready = 1'b1; zero = z;
        @(negedge clk); @(posedge clk); #1;
        mem_ready = 1'b0;
        @(negedge clk);
        n_vec++; if (pcen !== 1'b0) begin n_bad++; $display("FAIL beq_decode_pcen got %b want 0", pcen); end
        @(posedge clk); #1;
        @(negedge clk);
        n_vec++; if (state !== 4'd8) begin n_bad++; $display("FAIL beq_state got %0d want 8", state); end
        n_vec++; if ({pcen, pcsrc, aluop, alusrca} !== {z, 2'b01, 2'b01, 1'b1}) begin
            n_bad++; $display("FAIL beq_ex(zero=%b) got %b want %b", z, {pcen, pcsrc, aluop, alusrca}, {z, 2'b01, 2'b01, 1'b1});
        end
        @(posedge clk); #1;
        n_vec++; if (state !== 4'd0) begin n_bad++; $display("FAIL beq_end got %0d want 0", state); end
        zero = 1'b0;
    endtask

    task automatic test_illegal;
        logic il [3];
        il = '{1'b0, 1'b1, 1'b0};
        opcode = 6'b111111;
        for (int i = 0; i < 3; i++) begin
            mem_ready = (i == 0);
            @(negedge clk);
            n_vec++; if (illegal_op !== il[i]) begin n_bad++; $display("FAIL illegal_flag[%0d] got %b want %b", i, illegal_op, il[i]); end
            n_vec++; if ({regwrite, memwrite} !== 2'b00) begin n_bad++; $display("FAIL illegal_writes[%0d] got %b want 00", i, {regwrite, memwrite}); end
            @(posedge clk); #1;
        end
        n_vec++; if (state !== 4'd0) begin n_bad++; $display("FAIL illegal_end got %0d want 0", state); end
    endtask

    task automatic test_reset_midwrite;
        opcode = OP_SW; mem_ready = 1'b1;
        repeat (3) begin @(negedge clk); @(posedge clk); #1; end
        mem_ready = 1'b0;
        @(negedge clk);
        n_vec++; if ({state, memwrite} !== {4'd5, 1'b1}) begin n_bad++; $display("FAIL midwr_pre got %b want %b", {state, memwrite}, {4'd5, 1'b1}); end
        #2 rst_n = 1'b0;
        #1;
        n_vec++; if ({state, memwrite, mem_req} !== 6'b0) begin n_bad++; $display("FAIL midwr_abort got %b want 000000", {state, memwrite, mem_req}); end
        @(posedge clk); #1;
        rst_n = 1'b1; mem_ready = 1'b1; opcode = OP_J;
        @(negedge clk);
        n_vec++; if ({state, irwrite, mem_req} !== 6'b000011) begin n_bad++; $display("FAIL midwr_refetch got %b want 000011", {state, irwrite, mem_req}); end
        @(posedge clk); #1;
        @(negedge clk); @(posedge clk); #1;
        @(negedge clk);
        n_vec++; if ({state, pcen, pcsrc} !== {4'd9, 1'b1, 2'b10}) begin n_bad++; $display("FAIL midwr_jex got %b want %b", {state, pcen, pcsrc}, {4'd9, 1'b1, 2'b10}); end
        @(posedge clk); #1;
        n_vec++; if (state !== 4'd0) begin n_bad++; $display("FAIL midwr_end got %0d want 0", state); end
    endtask

    task automatic test_addi;
        opcode = OP_ADDI; mem_ready = 1'b1;
        @(negedge clk); @(posedge clk); #1;
        @(negedge clk);
`ifdef MCYCLE_ADDI_EN
        n_vec++; if (illegal_op !== 1'b0) begin n_bad++; $display("FAIL addi_flag got %b want 0", illegal_op); end
        @(posedge clk); #1;
        @(negedge clk);
        n_vec++; if ({state, alusrca, alusrcb} !== {4'd10, 1'b1, 2'b10}) begin n_bad++; $display("FAIL addi_ex got %b want %b", {state, alusrca, alusrcb}, {4'd10, 1'b1, 2'b10}); end
        @(posedge clk); #1;
        @(negedge clk);
        n_vec++; if ({state, regwrite, regdst} !== {4'd11, 1'b1, 1'b0}) begin n_bad++; $display("FAIL addi_wb got %b want %b", {state, regwrite, regdst}, {4'd11, 1'b1, 1'b0}); end
`else
        n_vec++; if (illegal_op !== 1'b1) begin n_bad++; $display("FAIL addi_flag got %b want 1", illegal_op); end
`endif
        @(posedge clk); #1;
        n_vec++; if (state !== 4'd0) begin n_bad++; $display("FAIL addi_end got %0d want 0", state); end
    endtask

    // Each instruction is a list of phases: memory phases (1) last until
    // mem_ready, other phases (0) take one cycle. Strobe totals follow from that.
    task automatic test_random;
        for (int k = 0; k < 200; k++) begin
            int sel, n, idx;
            int ph [5];
            logic [5:0] op;
            int e_req, e_mw, e_rw, e_pcen, e_ill;
            int g_req, g_mw, g_rw, g_pcen, g_ill, g_ir;
            sel = $urandom_range(0, 7);
            case (sel)
                0: op = OP_RTYPE;
                1: op = OP_LW;
                2: op = OP_SW;
                3: op = OP_BEQ;
                4: op = OP_ADDI;
                5: op = OP_J;
                default: op = 6'($urandom_range(0, 63));
            endcase
            opcode = op;
            zero = 1'($urandom_range(0, 1));
            ph = '{1, 0, 0, 0, 0};
            n = 2; e_rw = 0; e_ill = 0; e_pcen = 1;
            if (op == OP_LW) begin ph = '{1, 0, 0, 1, 0}; n = 5; e_rw = 1; end
            else if (op == OP_SW) begin ph = '{1, 0, 0, 1, 0}; n = 4; end
            else if (op == OP_RTYPE) begin n = 4; e_rw = 1; end
            else if (op == OP_BEQ) begin n = 3; e_pcen = 1 + int'(zero); end
            else if (op == OP_J) begin n = 3; e_pcen = 2; end
`ifdef MCYCLE_ADDI_EN
            else if (op == OP_ADDI) begin n = 4; e_rw = 1; end
`endif
            else e_ill = 1;
            idx = 0; e_req = 0; e_mw = 0;
            g_req = 0; g_mw = 0; g_rw = 0; g_pcen = 0; g_ill = 0; g_ir = 0;
            while (idx < n) begin
                mem_ready = ($urandom_range(0, 3) != 0);
                @(negedge clk);
                g_req += int'(mem_req); g_mw += int'(memwrite); g_rw += int'(regwrite);
                g_pcen += int'(pcen); g_ill += int'(illegal_op); g_ir += int'(irwrite);
                if (ph[idx] == 1) begin
                    e_req++;
                    if (op == OP_SW && idx == 3) e_mw++;
                    if (mem_ready) idx++;
                end else begin
                    idx++;
                end
                @(posedge clk); #1;
            end
            n_vec++; if (state !== 4'd0) begin n_bad++; $display("FAIL rnd%0d_end op=%b got state %0d want 0", k, op, state); end
            n_vec++; if (g_req != e_req) begin n_bad++; $display("FAIL rnd%0d_memreq op=%b got %0d want %0d", k, op, g_req, e_req); end
            n_vec++; if (g_mw != e_mw) begin n_bad++; $display("FAIL rnd%0d_memwrite op=%b got %0d want %0d", k, op, g_mw, e_mw); end
            n_vec++; if (g_rw != e_rw) begin n_bad++; $display("FAIL rnd%0d_regwrite op=%b got %0d want %0d", k, op, g_rw, e_rw); end
            n_vec++; if (g_pcen != e_pcen) begin n_bad++; $display("FAIL rnd%0d_pcen op=%b got %0d want %0d", k, op, g_pcen, e_pcen); end
            n_vec++; if (g_ill != e_ill) begin n_bad++; $display("FAIL rnd%0d_illegal op=%b got %0d want %0d", k, op, g_ill, e_ill); end
            n_vec++; if (g_ir != 1) begin n_bad++; $display("FAIL rnd%0d_irwrite op=%b got %0d want 1", k, op, g_ir); end
        end
    endtask

    initial begin
        test_reset;
        test_rtype;
        test_lw_stall;
        test_beq(1'b1);
        test_beq(1'b0);
        test_illegal;
        test_reset_midwrite;
        test_addi;
        test_random;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/mcycle_control.md
# mcycle_control

Multicycle main control FSM for the MIPS datapath. Sequences each instruction through fetch, decode, execute, memory and writeback states and produces the datapath strobes and mux selects. It is the producer of the 2-bit `aluop` consumed by the ALU control decoder, which combines it with the funct field. Memory accesses use a request/ready handshake so the datapath can stall on slow memory.

## Interface
- No parameters; all encodings come from the shared package.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `opcode` in 6: instr[31:26] from the instruction register.
- `zero` in 1: ALU zero flag.
- `mem_ready` in 1: memory completes the current access this cycle.
- `mem_req` out 1: memory access requested.
- `iord` out 1: memory address select (0 = PC, 1 = ALUOut).
- `memwrite` out 1: memory write strobe.
- `irwrite` out 1: instruction register load.
- `regdst` out 1: write register select (0 = rt, 1 = rd).
- `memtoreg` out 1: write data select (0 = ALUOut, 1 = MDR).
- `regwrite` out 1: register file write strobe.
- `alusrca` out 1: ALU A select (0 = PC, 1 = regA).
- `alusrcb` out 2: ALU B select (00 = regB, 01 = const 4, 10 = signext imm, 11 = signext imm<<2).
- `pcsrc` out 2: next-PC select (00 = ALU result, 01 = ALUOut, 10 = jump target).
- `aluop` out 2: 00 = add, 01 = sub, 10 = use funct.
- `pcen` out 1: PC load enable.
- `illegal_op` out 1: one-cycle flag for an unrecognised opcode.
- `state` out 4: current state, for debug.

## Operation
- Opcodes: R-type 000000, lw 100011, sw 101011, beq 000100, addi 001000, j 000010.
- States and transitions:
  - FETCH: go to DECODE when `mem_ready`, otherwise hold.
  - DECODE dispatches on opcode:
    - lw or sw: MEMADR.
    - R-type: RTYPEEX.
    - beq: BEQEX.
    - addi: ADDIEX.
    - j: JEX.
    - anything else: FETCH.
  - MEMADR: lw goes to MEMRD, sw goes to MEMWR.
  - MEMRD: go to MEMWB when `mem_ready`.
  - MEMWR: go to FETCH when `mem_ready`.
  - MEMWB, RTYPEWB, ADDIWB, BEQEX, JEX: go to FETCH.
  - RTYPEEX: go to RTYPEWB.
  - ADDIEX: go to ADDIWB.
- Outputs are a Moore decode of state. Every signal not listed for a state is 0.
  - FETCH: `mem_req`=1, `alusrcb`=01, `irwrite`=`mem_ready`, `pcwrite`=`mem_ready`.
  - DECODE: `alusrcb`=11.
  - MEMADR: `alusrca`=1, `alusrcb`=10.
  - MEMRD: `mem_req`=1, `iord`=1.
  - MEMWB: `regwrite`=1, `memtoreg`=1.
  - MEMWR: `mem_req`=1, `iord`=1, `memwrite`=1.
  - RTYPEEX: `alusrca`=1, `aluop`=10.
  - RTYPEWB: `regwrite`=1, `regdst`=1.
  - BEQEX: `alusrca`=1, `aluop`=01, `pcsrc`=01, `branch`=1.
  - ADDIEX: `alusrca`=1, `alusrcb`=10.
  - ADDIWB: `regwrite`=1.
  - JEX: `pcsrc`=10, `pcwrite`=1.
- `pcwrite` and `branch` are internal signals; `pcen` = `pcwrite` | (`branch` & `zero`).
- `illegal_op` = 1 in DECODE when the opcode is unrecognised; the instruction is treated as a NOP.
- `memwrite` stays high for every cycle of MEMWR, including stall cycles. Memory commits the write on the cycle where `mem_ready`=1.

## Timing
- State register: asynchronous clear to FETCH on `rst_n` low; updates on the rising clock edge.
- While `rst_n`=0:
  - `state`=FETCH, `alusrcb`=01.
  - `mem_req`, `irwrite`, `pcen`, `memwrite`, `regwrite`, `illegal_op` are forced to 0.
  - All other outputs are 0.
- Cycle counts with zero-wait memory:
  - lw: 5 cycles.
  - sw: 4 cycles.
  - R-type: 4 cycles.
  - addi: 4 cycles.
  - beq: 3 cycles.
  - j: 3 cycles.
  - Illegal opcode: 2 cycles.
- Each cycle with `mem_ready`=0 in FETCH, MEMRD or MEMWR adds one cycle. The state and all outputs are held during the stall.
- `zero` is sampled combinationally in BEQEX only.
- Reset asserted mid-instruction aborts it; no write strobe is asserted after `rst_n` falls.
- `mem_ready` asserted outside FETCH, MEMRD or MEMWR is ignored.

## Configuration
- `MCYCLE_ADDI_EN` defined: addi decodes to ADDIEX → ADDIWB.
- `MCYCLE_ADDI_EN` undefined: the ADDIEX and ADDIWB states are not built; opcode 001000 takes the illegal-op path (DECODE → FETCH with `illegal_op`=1).

## Structure
- Package `mcycle_pkg` holds:
  - The state enum (4-bit).
  - The opcode constants.
  - The `aluop`, `alusrcb` and `pcsrc` encodings.
- Sub-module `mcycle_outdec` is the pure combinational state→control decode. The top level holds the state register, next-state logic and the `pcen`/`illegal_op` glue.

## Test plan
- Reset then `mem_ready`=1, opcode=000000 (R-type): states FETCH, DECODE, RTYPEEX (`aluop`=10), RTYPEWB (`regwrite`=1, `regdst`=1), FETCH — 4 cycles.
- lw with `mem_ready` low for 2 cycles in MEMRD: 7 cycles total, `iord`=1 held throughout the stall, `regwrite`=1 with `memtoreg`=1 in MEMWB.
- beq with `zero`=1: `pcen`=1, `pcsrc`=01, `aluop`=01 in BEQEX. Repeat with `zero`=0: `pcen`=0.
- Opcode 111111: `illegal_op`=1 for exactly one cycle in DECODE, then FETCH, with no `regwrite` or `memwrite` asserted.
- `rst_n` driven low during MEMWR with `mem_ready`=0: `memwrite` goes to 0 immediately, `state`=FETCH, and fetch resumes after `rst_n` rises.
- addi: 4 cycles with `regwrite` in ADDIWB when `MCYCLE_ADDI_EN` is defined; `illegal_op`=1 when it is undefined.
